dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer that shares the single-port DataRAM between the processor core and an external host port (data preload, result readback, debug). It sits between the core's load/store path and the DataRAM. Each cycle it grants at most one requester and drives the RAM address, write-enable and write-data lines. Read data is returned with a one-cycle valid strobe. The core has fixed priority, with three exceptions: a host starvation counter, an exclusive host-lock mode, and a core stall output.

## Interface
- AW, 8, address width (matches DataRAM depth of 256).
- DW, 8, data width.
- STARVE_MAX, 4, host cycles waited while losing arbitration before a forced host grant; legal range 1..255.

- CLK  in  1  clock; all state updates on rising edge.
- start  in  1  synchronous active-high reset.
- core_req  in  1  core memory access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  core access performed this cycle.
- core_stall  out  1  core_req & ~core_gnt.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data.
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host request; same meaning as the core signals.
- host_lock  in  1  request for exclusive host ownership.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DW  host read data.
- host_locked  out  1  arbiter is in LOCKED state.
- ram_addr  out  AW  to DataRAM.
- ram_we  out  1  to DataRAM.
- ram_wdata  out  DW  to DataRAM.
- ram_rdata  in  DW  from DataRAM; valid the cycle after ram_addr is presented.

## Operation
- States: NORMAL, LOCKED. Reset state is NORMAL.
- NORMAL → LOCKED when host_lock=1 is sampled on an edge. LOCKED → NORMAL when host_lock=0 is sampled.
- Grant logic is combinational from the requests and registered state. At most one of core_gnt/host_gnt is high in any cycle.
  - LOCKED: host_gnt = host_req; core_gnt = 0.
  - NORMAL with starve_cnt == STARVE_MAX and host_req=1: host_gnt = 1, core_gnt = 0.
  - NORMAL otherwise: core_gnt = core_req; host_gnt = host_req & ~core_req.
- Starvation counter starve_cnt, width 8, saturating at STARVE_MAX:
  - Clears to 0 when host_req=0, when host_gnt=1, or when in LOCKED.
  - Increments when host_req=1 and host_gnt=0.
- RAM mux: ram_addr/ram_we/ram_wdata take the granted requester's fields.
  - With no grant: ram_we = 0, ram_addr holds its last value, ram_wdata = 0.
- Read return: a registered flag per port records "read granted last cycle". That flag drives core_rvalid/host_rvalid. The matching *_rdata passes ram_rdata through when its rvalid is high and is 0 otherwise.
- Writes produce no rvalid.
- The host may assert host_req together with host_lock. In the first cycle (before LOCKED is registered), NORMAL arbitration still applies.
- While start=1: grants 0, ram_we 0, core_stall 0.

## Timing
- Reset values (start=1 at an edge): state NORMAL, starve_cnt 0, both rvalid flags 0, host_locked 0, ram_addr 0. All outputs are 0 while start=1.
- Grant latency is 0 cycles: gnt rises in the same cycle as req when the requester wins.
- Write latency: the RAM write commits at the rising edge that ends the grant cycle.
- Read latency is 1 cycle: rvalid is high exactly in the cycle after the grant and lasts 1 cycle. Back-to-back reads from either port give an rvalid every cycle.
- Write followed by a read of the same address in the next cycle returns the new data.
- Forced host grant: with both ports requesting continuously from reset release, the host is granted in cycle STARVE_MAX+1. That is 4 core grants, then 1 host grant, repeating.
- Lock entry/exit takes effect on the cycle after the sampling edge.
- An in-flight read's rvalid is delivered even if the state changes on the same edge.
- Reset mid-operation: asserting start drops a pending rvalid. It does not appear in the cycle after reset.

## Test plan
- Reset: start=1 for 2 cycles with both reqs high → all outputs 0. After release, core_gnt=1 in the first cycle.
- Core only: core writes 0xA5 to 0x10, then reads 0x10 → core_rvalid=1 one cycle after the read grant, core_rdata=0xA5, host outputs 0.
- Contention: both ports issue continuous reads for 10 cycles, STARVE_MAX=4 → grant pattern C,C,C,C,H,C,C,C,C,H. core_stall=1 exactly in the H cycles. starve_cnt returns to 0 after each H.
- Lock: host_lock=1 at cycle 0; the host writes 0x01..0x08 to 0x20..0x27 while core_req=1 → host_locked=1 from cycle 1, core_gnt=0 and core_stall=1 throughout. After host_lock drops, core reads of 0x20..0x27 return 0x01..0x08.
- Host-only idle core: host reads 0xFF with core_req=0 → host_gnt=1 immediately, host_rvalid next cycle, starve_cnt stays 0.
- Reset during read: core read granted at cycle N, start=1 at cycle N+1 → core_rvalid=0 at N+1 and N+2, state NORMAL.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core load/store path, the host port and the
// single-port DataRAM. The arbiter takes the slave view; the surrounding
// environment (core, host and RAM) takes the master view.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  // core side
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  // host side
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_lock;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          host_locked;
  // DataRAM side
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata, host_locked,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata, host_locked,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// DataRAM arbiter: core has fixed priority, the host is force-granted after
// STARVE_MAX lost cycles, and the host can take exclusive ownership via
// host_lock. Grants are combinational; read data returns one cycle later.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input logic           CLK,
  input logic           start,
  dmem_arbiter_if.slave bus
);

  localparam logic [0:0] NORMAL     = 1'b0;
  localparam logic [0:0] LOCKED     = 1'b1;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [0:0]    state_r;
  logic [0:0]    stateNext_s;
  logic [7:0]    starveCnt_r;
  logic [7:0]    starveNext_s;
  logic          coreRdPend_r;
  logic          hostRdPend_r;
  logic [AW-1:0] addrHold_r;

  logic          coreGnt_s;
  logic          hostGnt_s;
  logic [AW-1:0] ramAddr_s;
  logic          ramWe_s;
  logic [DW-1:0] ramWdata_s;

  // Pick at most one requester from the current requests and registered state.
  always_comb begin
    coreGnt_s = 1'b0;
    hostGnt_s = 1'b0;
    if (start) begin
      coreGnt_s = 1'b0;
      hostGnt_s = 1'b0;
    end else if (state_r == LOCKED) begin
      hostGnt_s = bus.host_req;
    end else if (bus.host_req && (starveCnt_r == STARVE_LIM)) begin
      hostGnt_s = 1'b1;
    end else begin
      coreGnt_s = bus.core_req;
      hostGnt_s = bus.host_req & ~bus.core_req;
    end
  end

  // Next lock state and host starvation count (saturating at the limit).
  always_comb begin
    stateNext_s  = NORMAL;
    starveNext_s = 8'd0;
    if (start) begin
      stateNext_s  = NORMAL;
      starveNext_s = 8'd0;
    end else begin
      stateNext_s = bus.host_lock ? LOCKED : NORMAL;
      if ((state_r == LOCKED) || !bus.host_req || hostGnt_s) begin
        starveNext_s = 8'd0;
      end else if (starveCnt_r < STARVE_LIM) begin
        starveNext_s = starveCnt_r + 8'd1;
      end else begin
        starveNext_s = starveCnt_r;
      end
    end
  end

  // Steer the granted requester onto the RAM; the address parks when idle.
  always_comb begin
    ramAddr_s  = {AW{1'b0}};
    ramWe_s    = 1'b0;
    ramWdata_s = {DW{1'b0}};
    if (start) begin
      ramAddr_s = {AW{1'b0}};
    end else if (coreGnt_s) begin
      ramAddr_s  = bus.core_addr;
      ramWe_s    = bus.core_we;
      ramWdata_s = bus.core_wdata;
    end else if (hostGnt_s) begin
      ramAddr_s  = bus.host_addr;
      ramWe_s    = bus.host_we;
      ramWdata_s = bus.host_wdata;
    end else begin
      ramAddr_s = addrHold_r;
    end
  end

  // Register lock state, starvation count, parked address and read-return flags.
  always_ff @(posedge CLK) begin
    if (start) begin
      state_r      <= NORMAL;
      starveCnt_r  <= 8'd0;
      addrHold_r   <= {AW{1'b0}};
      coreRdPend_r <= 1'b0;
      hostRdPend_r <= 1'b0;
    end else begin
      state_r      <= stateNext_s;
      starveCnt_r  <= starveNext_s;
      addrHold_r   <= ramAddr_s;
      coreRdPend_r <= coreGnt_s & ~bus.core_we;
      hostRdPend_r <= hostGnt_s & ~bus.host_we;
    end
  end

  // A read in flight when start rises is dropped rather than delivered.
  assign bus.core_gnt    = coreGnt_s;
  assign bus.host_gnt    = hostGnt_s;
  assign bus.core_stall  = bus.core_req & ~coreGnt_s & ~start;
  assign bus.core_rvalid = coreRdPend_r & ~start;
  assign bus.host_rvalid = hostRdPend_r & ~start;
  assign bus.core_rdata  = bus.core_rvalid ? bus.ram_rdata : {DW{1'b0}};
  assign bus.host_rdata  = bus.host_rvalid ? bus.ram_rdata : {DW{1'b0}};
  assign bus.host_locked = (state_r == LOCKED) & ~start;
  assign bus.ram_addr    = ramAddr_s;
  assign bus.ram_we      = ramWe_s;
  assign bus.ram_wdata   = ramWdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level reference model with a shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int STARVE_MAX = 4;

  logic CLK = 1'b0;
  logic start;
  int   nCmp = 0;
  int   nBad = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (.CLK(CLK), .start(start), .bus(bus));

  always #5 CLK = ~CLK;

  // DataRAM model: synchronous write, registered read data.
  logic [7:0] ramArr [256];
  logic [7:0] ramRdataR = 8'd0;
  always @(posedge CLK) begin
    if (bus.ram_we) ramArr[bus.ram_addr] <= bus.ram_wdata;
    ramRdataR <= ramArr[bus.ram_addr];
  end
  assign bus.ram_rdata = ramRdataR;

  // Reference model state
  bit         mLocked;
  int         mWait;
  bit         mCP, mHP;
  logic [7:0] mCD, mHD, mLast;
  logic [7:0] mMem [256];
  logic       eCG, eHG, eStall, eCV, eHV, eLk, eW;
  logic [7:0] eCD, eHD, eA, eWD;
  logic [38:0] expVec;

  function automatic logic [38:0] obsVec();
    return {bus.core_gnt, bus.core_stall, bus.core_rvalid, bus.core_rdata,
            bus.host_gnt, bus.host_rvalid, bus.host_rdata, bus.host_locked,
            bus.ram_addr, bus.ram_we, bus.ram_wdata};
  endfunction

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                       input logic hl);
    bus.core_req = cr; bus.core_we = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
    bus.host_lock = hl;
  endtask

  // Expected outputs this cycle from the arbitration rules.
  task automatic model_eval();
    eCG = 1'b0; eHG = 1'b0;
    if (!start) begin
      if (mLocked) eHG = bus.host_req;
      else if (bus.host_req && mWait >= STARVE_MAX) eHG = 1'b1;
      else begin eCG = bus.core_req; eHG = bus.host_req && !bus.core_req; end
    end
    eStall = !start && bus.core_req && !eCG;
    eCV = !start && mCP; eCD = eCV ? mCD : 8'd0;
    eHV = !start && mHP; eHD = eHV ? mHD : 8'd0;
    eLk = !start && mLocked;
    if (start) begin eA = 8'd0; eW = 1'b0; eWD = 8'd0; end
    else if (eCG) begin eA = bus.core_addr; eW = bus.core_we; eWD = bus.core_wdata; end
    else if (eHG) begin eA = bus.host_addr; eW = bus.host_we; eWD = bus.host_wdata; end
    else begin eA = mLast; eW = 1'b0; eWD = 8'd0; end
    expVec = {eCG, eStall, eCV, eCD, eHG, eHV, eHD, eLk, eA, eW, eWD};
  endtask

  // Advance the model by one clock edge.
  task automatic model_commit();
    if (start) begin
      mLocked = 1'b0; mWait = 0; mCP = 1'b0; mHP = 1'b0; mLast = 8'd0;
    end else begin
      mCP = eCG && !bus.core_we; mCD = mMem[bus.core_addr];
      mHP = eHG && !bus.host_we; mHD = mMem[bus.host_addr];
      if (eW) mMem[eA] = eWD;
      mWait = (mLocked || !bus.host_req || eHG) ? 0 : mWait + 1;
      mLocked = bus.host_lock;
      mLast = eA;
    end
  endtask

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    drive(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      nCmp++;
      if (obsVec() !== 39'd0) begin nBad++; $display("FAIL reset_outputs cyc%0d got=%h want=0", i, obsVec()); end
      tick();
    end
    start = 1'b0;
    settle();
    nCmp++;
    if ({bus.core_gnt, bus.host_gnt} !== 2'b10) begin nBad++; $display("FAIL reset_release_gnt got=%b want=10", {bus.core_gnt, bus.host_gnt}); end
    nCmp++;
    if (obsVec() !== expVec) begin nBad++; $display("FAIL reset_release_model got=%h want=%h", obsVec(), expVec); end
    tick();
  endtask

  task automatic test_core_only();
    drive(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.core_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b1, 8'h10, 8'hA5}) begin
      nBad++; $display("FAIL core_write got=%b/%b/%h/%h want=1/1/10/a5", bus.core_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    tick();
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.core_gnt, bus.core_rvalid, bus.ram_we} !== 3'b100) begin nBad++; $display("FAIL core_read_gnt got=%b want=100", {bus.core_gnt, bus.core_rvalid, bus.ram_we}); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.core_rvalid, bus.core_rdata} !== {1'b1, 8'hA5}) begin nBad++; $display("FAIL core_readback got=%b/%h want=1/a5", bus.core_rvalid, bus.core_rdata); end
    nCmp++;
    if ({bus.host_gnt, bus.host_rvalid, bus.host_rdata, bus.host_locked} !== 11'd0) begin nBad++; $display("FAIL core_only_host_quiet got=%b/%b/%h/%b want=0", bus.host_gnt, bus.host_rvalid, bus.host_rdata, bus.host_locked); end
    tick();
  endtask

  task automatic test_contention();
    logic hExp;
    logic cvExp;
    start = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle(); tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'b0);
      settle();
      hExp = (i % 5 == 4);
      nCmp++;
      if ({bus.core_gnt, bus.host_gnt, bus.core_stall} !== {~hExp, hExp, hExp}) begin
        nBad++; $display("FAIL contention_pattern cyc%0d got=%b want=%b", i, {bus.core_gnt, bus.host_gnt, bus.core_stall}, {~hExp, hExp, hExp});
      end
      if (i > 0) begin
        cvExp = ((i - 1) % 5 != 4);
        nCmp++;
        if ({bus.core_rvalid, bus.host_rvalid} !== {cvExp, ~cvExp}) begin
          nBad++; $display("FAIL contention_rvalid cyc%0d got=%b want=%b", i, {bus.core_rvalid, bus.host_rvalid}, {cvExp, ~cvExp});
        end
      end
      nCmp++;
      if (obsVec() !== expVec) begin nBad++; $display("FAIL contention_model cyc%0d got=%h want=%h", i, obsVec(), expVec); end
      tick();
    end
  endtask

  task automatic test_lock();
    int idx = 0;
    int cyc = 0;
    while (idx < 8 && cyc < 40) begin
      drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'(8'h20 + idx), 8'(idx + 1), 1'b1);
      settle();
      if (cyc == 0) begin
        nCmp++;
        if ({bus.host_locked, bus.core_gnt, bus.host_gnt} !== 3'b010) begin nBad++; $display("FAIL lock_first_cycle got=%b want=010", {bus.host_locked, bus.core_gnt, bus.host_gnt}); end
      end else begin
        nCmp++;
        if ({bus.host_locked, bus.core_gnt, bus.core_stall, bus.host_gnt} !== 4'b1011) begin
          nBad++; $display("FAIL lock_hold cyc%0d got=%b want=1011", cyc, {bus.host_locked, bus.core_gnt, bus.core_stall, bus.host_gnt});
        end
      end
      nCmp++;
      if (obsVec() !== expVec) begin nBad++; $display("FAIL lock_model cyc%0d got=%h want=%h", cyc, obsVec(), expVec); end
      if (bus.host_gnt) idx++;
      tick();
      cyc++;
    end
    nCmp++;
    if (idx != 8) begin nBad++; $display("FAIL lock_writes_done got=%0d want=8", idx); end
    // host_lock drops; LOCKED still holds this one cycle
    drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.host_locked, bus.core_gnt} !== 2'b10) begin nBad++; $display("FAIL unlock_delay got=%b want=10", {bus.host_locked, bus.core_gnt}); end
    tick();
    for (int k = 0; k <= 8; k++) begin
      drive(k < 8, 1'b0, 8'(8'h20 + k), 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      settle();
      if (k < 8) begin
        nCmp++;
        if ({bus.host_locked, bus.core_gnt} !== 2'b01) begin nBad++; $display("FAIL unlock_core_gnt k%0d got=%b want=01", k, {bus.host_locked, bus.core_gnt}); end
      end
      if (k > 0) begin
        nCmp++;
        if ({bus.core_rvalid, bus.core_rdata} !== {1'b1, 8'(k)}) begin
          nBad++; $display("FAIL lock_readback k%0d got=%b/%h want=1/%h", k, bus.core_rvalid, bus.core_rdata, 8'(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_host_only();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.host_gnt, bus.core_gnt, bus.ram_addr} !== {2'b10, 8'hFF}) begin nBad++; $display("FAIL host_only_gnt got=%b/%b/%h want=1/0/ff", bus.host_gnt, bus.core_gnt, bus.ram_addr); end
    tick();
    // host idle next cycle, core now requests: no starvation was counted
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.host_rvalid, bus.host_rdata, bus.core_gnt} !== {1'b1, 8'hA5, 1'b1}) begin
      nBad++; $display("FAIL host_only_readback got=%b/%h/%b want=1/a5/1", bus.host_rvalid, bus.host_rdata, bus.core_gnt);
    end
    tick();
  endtask

  task automatic test_reset_during_read();
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if (bus.core_gnt !== 1'b1) begin nBad++; $display("FAIL rst_read_gnt got=%b want=1", bus.core_gnt); end
    tick();
    start = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    nCmp++;
    if ({bus.core_rvalid, bus.core_rdata} !== 9'd0) begin nBad++; $display("FAIL rst_read_n1 got=%b/%h want=0/00", bus.core_rvalid, bus.core_rdata); end
    tick();
    start = 1'b0;
    settle();
    nCmp++;
    if ({bus.core_rvalid, bus.host_locked} !== 2'b00) begin nBad++; $display("FAIL rst_read_n2 got=%b want=00", {bus.core_rvalid, bus.host_locked}); end
    tick();
  endtask

  task automatic test_random();
    logic hl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) hl = ~hl;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), hl);
      settle();
      nCmp++;
      if (obsVec() !== expVec) begin nBad++; $display("FAIL random cyc%0d got=%h want=%h", i, obsVec(), expVec); end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ramArr[i] = 8'(i) ^ 8'h5A;
      mMem[i]   = 8'(i) ^ 8'h5A;
    end
    mLocked = 1'b0; mWait = 0; mCP = 1'b0; mHP = 1'b0; mCD = 8'd0; mHD = 8'd0; mLast = 8'd0;
    start = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge CLK);
    #1;
    test_reset();
    test_core_only();
    test_contention();
    test_lock();
    test_host_only();
    test_reset_during_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
